signed_sort_ctrl: RTL and testbench

//  Sequential sort controller built around one shared 4-bit two's-complement comparator.
//  - Accepts a frame of DEPTH signed words on a valid/ready input stream.
//  - Bubble-sorts the frame in place, one compare per cycle, on a single comparator instance.
//  - Emits the frame in ascending signed order on a valid/ready output stream.
//  - Sits between a sample source and any consumer needing ordered signed data (min/max/median).

---
 rtl/signed_sort_pkg.sv | 21 ++
 rtl/signed_cmp.sv | 31 +++
 rtl/signed_sort_ctrl.sv | 157 +++++++++++++++
 tb/tb_signed_sort_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/signed_sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signed_sort_pkg
// Description : Shared state encoding and default sizes for the signed sorter.
// Revision    : 1.0 - initial release
// ============================================================================
package signed_sort_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 4;
    localparam int SWAP_W        = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/signed_cmp.sv
`default_nettype none
// ============================================================================
// Module      : signed_cmp
// Description : Combinational two's-complement magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_cmp
    import signed_sort_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    logic w_sign_diff;
    logic w_raw_gt;

    assign w_sign_diff = a_i[WIDTH-1] ^ b_i[WIDTH-1];
    assign w_raw_gt    = (a_i > b_i);

    // A negative word is always below a non-negative one; otherwise raw order holds.
    assign gt_o = w_sign_diff ? ~a_i[WIDTH-1] : w_raw_gt;
    assign eq_o = (a_i == b_i);
    assign lt_o = ~gt_o & ~eq_o;

endmodule
`default_nettype wire

// File: rtl/signed_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : signed_sort_ctrl
// Description : Frame-based in-place bubble sorter on a single shared comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_sort_ctrl
    import signed_sort_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [WIDTH-1:0]  out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic [SWAP_W-1:0] swaps_o
);

    localparam logic [CNT_W-1:0] c_IDX_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_IDX_CMP  = CNT_W'(DEPTH - 2);

    state_e             state_q;
    logic [CNT_W-1:0]   idx_q;
    logic               pass_swap_q;
    logic [SWAP_W-1:0]  swaps_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic [CNT_W-1:0]   w_idx_inc;
    logic [CNT_W-1:0]   w_idx_b;
    logic               w_idx_last;
    logic [WIDTH-1:0]   w_cmp_a;
    logic [WIDTH-1:0]   w_cmp_b;
    logic               w_gt;
    logic               w_eq;
    logic               w_lt;
    logic               w_unused_cmp;
    logic               w_swap;
    logic [SWAP_W-1:0]  swaps_d;

    assign w_idx_inc  = idx_q + CNT_W'(1);
    assign w_idx_last = (idx_q == c_IDX_LAST);
    // Keep the second read port in range when idx sits on the last entry.
    assign w_idx_b    = w_idx_last ? idx_q : w_idx_inc;
    assign w_cmp_a    = mem_q[idx_q];
    assign w_cmp_b    = mem_q[w_idx_b];

    signed_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a_i  (w_cmp_a),
        .b_i  (w_cmp_b),
        .gt_o (w_gt),
        .eq_o (w_eq),
        .lt_o (w_lt)
    );

    assign w_unused_cmp = w_eq ^ w_lt;
    assign w_swap       = (state_q == ST_SORT) && w_gt;
    assign swaps_d      = (swaps_q == {SWAP_W{1'b1}}) ? swaps_q : swaps_q + SWAP_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            pass_swap_q <= 1'b0;
            swaps_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid_i) begin
                        mem_q[idx_q] <= in_data_i;
                        if (w_idx_last) begin
                            idx_q       <= '0;
                            pass_swap_q <= 1'b0;
                            swaps_q     <= '0;
                            in_ready_q  <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_SORT;
                        end else begin
                            idx_q <= w_idx_inc;
                        end
                    end
                end

                ST_SORT: begin
                    if (w_swap) begin
                        mem_q[idx_q]     <= w_cmp_b;
                        mem_q[w_idx_inc] <= w_cmp_a;
                        swaps_q          <= swaps_d;
                    end
                    if (idx_q == c_IDX_CMP) begin
                        idx_q       <= '0;
                        pass_swap_q <= 1'b0;
                        // A clean pass means memory is final, so entry 0 is safe to present.
                        if (!(pass_swap_q || w_swap)) begin
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= mem_q[0];
                            state_q     <= ST_DRAIN;
                        end
                    end else begin
                        idx_q       <= w_idx_inc;
                        pass_swap_q <= pass_swap_q | w_swap;
                    end
                end

                ST_DRAIN: begin
                    if (out_ready_i) begin
                        if (w_idx_last) begin
                            idx_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_LOAD;
                        end else begin
                            idx_q      <= w_idx_inc;
                            out_data_q <= w_cmp_b;
                        end
                    end
                end

                default: begin
                    state_q     <= ST_LOAD;
                    idx_q       <= '0;
                    pass_swap_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    out_data_q  <= '0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;
    assign swaps_o     = swaps_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_sort_ctrl
// Description : Directed self-checking bench for the signed sort controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_sort_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] swaps;

    int n_pass;
    int n_total;

    logic [3:0] cur_in [4];

    signed_sort_ctrl #(
        .WIDTH (4),
        .DEPTH (4),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .swaps_o     (swaps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = cur_in[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 300) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        tick();
        tick();
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (out_data !== 4'h0) $display("FAIL reset_out_data: got %h expected 0", out_data); else n_pass++;
        n_total++; if (swaps !== 8'd0) $display("FAIL reset_swaps: got %0d expected 0", swaps); else n_pass++;
        rst = 1'b0;
    endtask

    // Frames 0..3: mixed, already sorted, reversed, duplicates.
    task automatic test_frames();
        logic [3:0] tab_in  [4][4];
        logic [3:0] tab_out [4][4];
        int         tab_busy  [4];
        int         tab_swaps [4];
        int         cyc;
        tab_in[0] = '{4'h0, 4'h8, 4'h6, 4'h2}; tab_out[0] = '{4'h8, 4'h0, 4'h2, 4'h6};
        tab_in[1] = '{4'h8, 4'hF, 4'h0, 4'h7}; tab_out[1] = '{4'h8, 4'hF, 4'h0, 4'h7};
        tab_in[2] = '{4'h7, 4'h0, 4'hF, 4'h8}; tab_out[2] = '{4'h8, 4'hF, 4'h0, 4'h7};
        tab_in[3] = '{4'h2, 4'h2, 4'hD, 4'h2}; tab_out[3] = '{4'hD, 4'h2, 4'h2, 4'h2};
        tab_busy  = '{6, 3, 12, 9};
        tab_swaps = '{2, 0, 6, 2};
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 4; i++) cur_in[i] = tab_in[f][i];
            load_frame();
            count_busy(cyc);
            n_total++; if (cyc != tab_busy[f]) $display("FAIL frame%0d_busy_cycles: got %0d expected %0d", f, cyc, tab_busy[f]); else n_pass++;
            n_total++; if (swaps !== 8'(tab_swaps[f])) $display("FAIL frame%0d_swaps: got %0d expected %0d", f, swaps, tab_swaps[f]); else n_pass++;
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                n_total++; if (out_valid !== 1'b1 || out_data !== tab_out[f][i]) $display("FAIL frame%0d_out%0d: got v=%b d=%h expected v=1 d=%h", f, i, out_valid, out_data, tab_out[f][i]); else n_pass++;
                tick();
            end
            out_ready = 1'b0;
            n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL frame%0d_back_to_load: got rdy=%b v=%b expected rdy=1 v=0", f, in_ready, out_valid); else n_pass++;
        end
    endtask

    // Stall the consumer mid-drain; junk on the input while not loading.
    task automatic test_backpressure();
        logic [3:0] exp_out [4];
        int         cyc;
        cur_in  = '{4'h5, 4'hE, 4'h3, 4'h9};
        exp_out = '{4'h9, 4'hE, 4'h3, 4'h5};
        load_frame();
        in_valid = 1'b1;
        in_data  = 4'h1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_sort: got %b expected 0", in_ready); else n_pass++;
        count_busy(cyc);
        n_total++; if (cyc != 12) $display("FAIL bp_busy_cycles: got %0d expected 12", cyc); else n_pass++;
        n_total++; if (swaps !== 8'd5) $display("FAIL bp_swaps: got %0d expected 5", swaps); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_total++; if (out_valid !== 1'b1 || out_data !== exp_out[i]) $display("FAIL bp_out%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp_out[i]); else n_pass++;
            tick();
        end
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_total++; if (out_valid !== 1'b1 || out_data !== exp_out[2]) $display("FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=%h", s, out_valid, out_data, exp_out[2]); else n_pass++;
        end
        out_ready = 1'b1;
        for (int i = 2; i < 4; i++) begin
            n_total++; if (out_valid !== 1'b1 || out_data !== exp_out[i]) $display("FAIL bp_out%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp_out[i]); else n_pass++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_back_to_load: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid_sort();
        logic [3:0] exp_out [4];
        int         cyc;
        cur_in = '{4'h7, 4'h0, 4'hF, 4'h8};
        load_frame();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_sort_flags: got rdy=%b v=%b busy=%b expected 1 0 0", in_ready, out_valid, busy); else n_pass++;
        n_total++; if (swaps !== 8'd0) $display("FAIL rst_sort_swaps: got %0d expected 0", swaps); else n_pass++;
        cur_in  = '{4'h0, 4'h8, 4'h6, 4'h2};
        exp_out = '{4'h8, 4'h0, 4'h2, 4'h6};
        load_frame();
        count_busy(cyc);
        n_total++; if (cyc != 6 || swaps !== 8'd2) $display("FAIL rst_new_frame_sort: got busy=%0d swaps=%0d expected busy=6 swaps=2", cyc, swaps); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (out_valid !== 1'b1 || out_data !== exp_out[i]) $display("FAIL rst_new_out%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp_out[i]); else n_pass++;
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        out_ready = 1'b0;
        test_reset();
        test_frames();
        test_backpressure();
        test_reset_mid_sort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
